sorted_insert_ctrl: RTL
=======================

// Module: sorted_insert_ctrl
// PURPOSE
// - Upstream controller for the indexed right-shift/insert stage.
// - Holds a 16 x 32-bit ascending-sorted array register and accepts a valid/ready stream of keys.
// - For each accepted key it computes the insertion index and drives the shifter, then registers the
//   shifter result. On flush it streams the sorted contents out in order.
// PARAMETERS
// - DATA_W  32  key width; fixed at 32 to match the shifter's 32-bit lanes
// - DEPTH   16  array entries; fixed at 16 to match the shifter's 4-bit index / 512-bit array
// PORTS
// - clk          in   1    clock; all state updates on rising edge
// - rst_n        in   1    synchronous reset, active-low
// - in_valid     in   1    key beat valid
// - in_ready     out  1    controller can accept a key this cycle
// - in_data      in   32   key, unsigned
// - flush        in   1    request drain of current contents (sampled in FILL only)
// - out_valid    out  1    drained key valid
// - out_ready    in   1    downstream accepts drained key
// - out_data     out  32   drained key, ascending order
// - out_last     out  1    marks final drained key
// - count        out  5    number of valid entries, 0..16
// - dup_hit      out  1    1-cycle pulse: key dropped as duplicate (DEDUP_EN only, else 0)
// - rsh_arr      out  512  to shifter arr: current array register, lane i = bits [32i+31:32i]
// - rsh_idx      out  4    to shifter idx: insertion index
// - rsh_val      out  32   to shifter insert_value: equals in_data
// - rsh_new_arr  in   512  from shifter new_arr (combinational return)
// BEHAVIOUR
// - Reset (rst_n=0 at edge)
//   - state=FILL; count=0; rd_ptr=0; array register=0
//   - in_ready=0 during reset; out_valid=0; out_last=0; dup_hit=0
// - States
//   - FILL:  in_ready = (count<16); out_valid=0
//   - DRAIN: in_ready=0; out_valid=1
// - Index (combinational)
//   - rsh_idx = number of lanes i<count with arr[i] <= in_data (unsigned)
//   - Equal keys land after existing equals (stable order).
//   - Lanes >= count are ignored by the comparison.
// - Insert: on in_valid & in_ready, at the next edge array <= rsh_new_arr and count <= count+1.
//   - Latency 1 cycle; a back-to-back insert is sustained every cycle.
//   - Lane 15 is shifted out only when it is invalid, because insertion is blocked when count==16.
// - FILL -> DRAIN: flush=1 and (count>0 or an insert occurs in the same cycle).
//   - A same-cycle insert is committed and included in the drain.
//   - flush with count==0 and no insert: ignored; stays in FILL.
// - DRAIN
//   - out_data = arr[rd_ptr]; out_last = (rd_ptr==count-1).
//   - On out_valid & out_ready, rd_ptr++.
//   - On the last handshake: count<=0, rd_ptr<=0, array cleared, state<=FILL.
//   - out_ready=0 holds out_data and out_last stable.
//   - flush and in_valid are ignored in DRAIN.
// - Full: count==16 -> in_ready=0; keys stall upstream until a drain completes.
// - Reset mid-drain: remaining entries are discarded; reset values as above.
// CONFIGURATION
// - DEDUP_EN defined
//   - If in_data equals any valid lane, the beat is accepted (in_ready unchanged) but not inserted.
//   - count and the array are unchanged; dup_hit=1 for exactly the next cycle.
//   - A duplicate offered with count==16 stalls like any other key (in_ready=0).
// - DEDUP_EN undefined: duplicates are inserted after equals; dup_hit is tied 0.
// TESTING
// - Insert 7,3,9,3 then flush, out_ready=1 -> out 3,3,7,9; out_last on 9; count returns 0.
// - Insert 16 descending keys 16..1 -> count=16, in_ready=0; 17th key stalls; drain emits 1..16.
// - flush and in_valid(5) in same cycle with count=2 {2,8} -> drain emits 2,5,8.
// - During drain toggle out_ready 1,0,0,1 -> out_data held while stalled; no skips or repeats.
// - Assert rst_n=0 after 2 of 4 drained keys -> next cycle out_valid=0, count=0, in_ready=1 after release.
// - DEDUP_EN: insert 4,4,0xFFFFFFFF,4 -> count=2, dup_hit pulses twice; drain 4,0xFFFFFFFF.

Source files
------------

// File: rtl/sorted_insert_ctrl.sv
// sorted_insert_ctrl: sorted 16x32 insert controller with flush drain; define DEDUP_EN to drop duplicate keys
module sorted_insert_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [4:0]              count,
  output logic                    dup_hit,
  output logic [DATA_W*DEPTH-1:0] rsh_arr,
  output logic [3:0]              rsh_idx,
  output logic [DATA_W-1:0]       rsh_val,
  input  logic [DATA_W*DEPTH-1:0] rsh_new_arr
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nxt;
  logic [DATA_W*DEPTH-1:0] arr;
  logic [DATA_W-1:0] lane [DEPTH];
  logic [3:0] rd_ptr, idx;
  logic accept, insert, out_fire, last_fire;
  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign lane[g] = arr[g*DATA_W +: DATA_W];
  end
`ifdef DEDUP_EN
  logic dup, dup_q;
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      dup = dup | ((5'(i) < count) && (lane[i] == in_data));
  end
  assign insert  = accept & ~dup;
  assign dup_hit = dup_q;
  always_ff @(posedge clk)
    dup_q <= rst_n & accept & dup;
`else
  assign insert  = accept;
  assign dup_hit = 1'b0;
`endif
  // Only valid lanes vote; equal keys count as "before", so new equals land after old ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++)
      idx = idx + 4'((5'(i) < count) && (lane[i] <= in_data));
  end
  assign rsh_arr   = arr;
  assign rsh_idx   = idx;
  assign rsh_val   = in_data;
  assign in_ready  = rst_n && state == FILL && !count[4];
  assign out_valid = rst_n && state == DRAIN;
  assign out_data  = lane[rd_ptr];
  assign out_last  = out_valid && rd_ptr == 4'(count - 5'd1);
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_fire = out_fire & out_last;
  always_comb begin
    state_nxt = state;
    if (state == FILL)
      state_nxt = (flush && (count != 5'd0 || insert)) ? DRAIN : FILL;
    else
      state_nxt = last_fire ? FILL : DRAIN;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= FILL;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!rst_n || last_fire) begin
      arr    <= '0;
      count  <= '0;
      rd_ptr <= '0;
    end else if (out_fire) begin
      rd_ptr <= rd_ptr + 4'd1;
    end else if (insert) begin
      arr   <= rsh_new_arr;
      count <= count + 5'd1;
    end
endmodule
